// File: rtl/snn_step_ctrl_if.sv
// rtl/snn_step_ctrl_if.sv - host/datapath handshake bundle for snn_step_ctrl
// master drives requests and spike flags; slave is the step controller.
interface snn_step_ctrl_if #(
  parameter int W_BITS   = 5,
  parameter int CNT_BITS = 16
);
  logic                    start;
  logic                    wclr;
  logic                    pre_a;
  logic                    pre_b;
  logic                    post_1;
  logic                    post_2;
  logic                    sample_en;
  logic                    l1_en;
  logic                    l2_en;
  logic                    busy;
  logic                    done;
  logic [4*W_BITS-1:0]     w_out;
  logic [CNT_BITS-1:0]     step_cnt;

  modport master (
    output start, wclr, pre_a, pre_b, post_1, post_2,
    input  sample_en, l1_en, l2_en, busy, done, w_out, step_cnt
  );

  modport slave (
    input  start, wclr, pre_a, pre_b, post_1, post_2,
    output sample_en, l1_en, l2_en, busy, done, w_out, step_cnt
  );
endinterface

// File: rtl/snn_step_ctrl.sv
// rtl/snn_step_ctrl.sv - 2x2 spiking-network step sequencer with saturating spike-driven weights
// Optional learning phase (UPD) is built only when SNN_STEP_CTRL_LEARN_EN is defined.
module snn_step_ctrl #(
  parameter int W_BITS   = 5,
  parameter int CNT_BITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  snn_step_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    L1   = 3'd2,
    L2   = 3'd3,
    UPD  = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic signed [W_BITS-1:0] W_MAX = {1'b0, {(W_BITS-1){1'b1}}};
  localparam logic signed [W_BITS-1:0] W_MIN = {1'b1, {(W_BITS-1){1'b0}}};

  state_t                    state;
  state_t                    nxt;
  logic signed [W_BITS-1:0]  w1, w2, w3, w4;
  logic                      pre_a_q, pre_b_q, post_1_q, post_2_q;
  logic                      sample_en_q, l1_en_q, l2_en_q, busy_q, done_q;
  logic [CNT_BITS-1:0]       step_cnt_q;

  // Coincident pre/post strengthens; a lone pre or lone post weakens.
  function automatic logic signed [W_BITS-1:0] learn(
    input logic signed [W_BITS-1:0] w,
    input logic                     pre,
    input logic                     post
  );
    logic signed [W_BITS-1:0] r;
    r = w;
    if (pre && post) begin
      if (w != W_MAX) r = w + W_BITS'(1);
    end else if (pre || post) begin
      if (w != W_MIN) r = w - W_BITS'(1);
    end
    return r;
  endfunction

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (bus.start) nxt = LOAD;
      LOAD: nxt = L1;
      L1:   nxt = L2;
`ifdef SNN_STEP_CTRL_LEARN_EN
      L2:   nxt = UPD;
`else
      L2:   nxt = DONE;
`endif
      UPD:  nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they line up with the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sample_en_q <= 1'b0;
      l1_en_q     <= 1'b0;
      l2_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pre_a_q     <= 1'b0;
      pre_b_q     <= 1'b0;
      post_1_q    <= 1'b0;
      post_2_q    <= 1'b0;
      w1          <= '0;
      w2          <= '0;
      w3          <= '0;
      w4          <= '0;
      step_cnt_q  <= '0;
    end else begin
      state       <= nxt;
      sample_en_q <= (nxt == LOAD);
      l1_en_q     <= (nxt == L1);
      l2_en_q     <= (nxt == L2);
      busy_q      <= (nxt == LOAD) || (nxt == L1) || (nxt == L2) || (nxt == UPD);
      done_q      <= (nxt == DONE);

      if (state == L1) begin
        pre_a_q <= bus.pre_a;
        pre_b_q <= bus.pre_b;
      end
      if (state == L2) begin
        post_1_q <= bus.post_1;
        post_2_q <= bus.post_2;
      end

      // UPD is unreachable without the learning build, so weights then only clear.
      if (state == IDLE && bus.wclr) begin
        w1 <= '0;
        w2 <= '0;
        w3 <= '0;
        w4 <= '0;
      end else if (state == UPD) begin
        w1 <= learn(w1, pre_a_q, post_1_q);
        w2 <= learn(w2, pre_a_q, post_2_q);
        w3 <= learn(w3, pre_b_q, post_1_q);
        w4 <= learn(w4, pre_b_q, post_2_q);
      end

      if (state == DONE) step_cnt_q <= step_cnt_q + CNT_BITS'(1);
    end
  end

  assign bus.sample_en = sample_en_q;
  assign bus.l1_en     = l1_en_q;
  assign bus.l2_en     = l2_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.w_out     = {w4, w3, w2, w1};
  assign bus.step_cnt  = step_cnt_q;

endmodule
